// File: rtl/bus_pkg.sv
// Shared types for the instruction/data cache memory arbiter.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_F = 2'd1,
      GRANT_M = 2'd2
   } arb_state_t;

   localparam int BEATS_DEFAULT = 4;

endpackage

// File: rtl/mux2.sv
// Generic two-input multiplexer; sel=1 picks b.
module mux2 #(
   parameter int W = 32
) (
   input  logic         sel,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the fetch (F) and
// data (M) cache controllers, forwarding beat-addressed burst transfers.
module cache_bus_arbiter
   import bus_pkg::*;
#(
   parameter int BEATS = BEATS_DEFAULT,
   parameter int ADDRW = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             HRequestF,
   input  logic [ADDRW-1:0] HAddrF,
   output logic             HReadyF,
   input  logic             HRequestM,
   input  logic             HWriteM,
   input  logic [ADDRW-1:0] HAddrM,
   input  logic [31:0]      HWDataM,
   output logic             HReadyM,
   output logic [31:0]      HRData,
   output logic             MemReq,
   output logic             MemWrite,
   output logic [ADDRW-1:0] MemAddr,
   output logic [31:0]      MemWData,
   input  logic [31:0]      MemRData,
   input  logic             MemReady
);

   localparam int BW = $clog2(BEATS);
   localparam logic [BW-1:0] BEAT_ONE = BW'(1);

   arb_state_t       state_q, state_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic             last_m_q, last_m_d;
   logic             sel_m;
   logic [ADDRW-1:0] addr_sel;
   logic             unused_low;

   assign sel_m = (state_q == GRANT_M);

   mux2 #(.W(ADDRW)) u_addr_mux (
      .sel (sel_m),
      .a   (HAddrF),
      .b   (HAddrM),
      .y   (addr_sel)
   );

   // Byte/beat offset bits of the requester address are replaced by the beat counter.
   assign unused_low = ^addr_sel[BW+1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         beat_q   <= '0;
         last_m_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         beat_q   <= beat_d;
         last_m_q <= last_m_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      last_m_d = last_m_q;
      HReadyF  = 1'b0;
      HReadyM  = 1'b0;
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      case (state_q)
         IDLE: begin
            beat_d = '0;
            // On a tie the side that did not own the bus last time wins.
            if (HRequestF && HRequestM)
               state_d = last_m_q ? GRANT_F : GRANT_M;
            else if (HRequestF)
               state_d = GRANT_F;
            else if (HRequestM)
               state_d = GRANT_M;
         end
         GRANT_F: begin
            MemReq  = HRequestF;
            HReadyF = MemReady;
            if (!HRequestF) begin
               state_d  = IDLE;
               beat_d   = '0;
               last_m_d = 1'b0;
            end else if (MemReady) begin
               beat_d = beat_q + BEAT_ONE;
            end
         end
         GRANT_M: begin
            MemReq   = HRequestM;
            MemWrite = HRequestM & HWriteM;
            HReadyM  = MemReady;
            if (!HRequestM) begin
               state_d  = IDLE;
               beat_d   = '0;
               last_m_d = 1'b1;
            end else if (MemReady) begin
               beat_d = beat_q + BEAT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            beat_d  = '0;
         end
      endcase
   end

   assign MemAddr  = MemReq ? {addr_sel[ADDRW-1:BW+2], beat_q, 2'b00} : '0;
   assign MemWData = MemReq ? HWDataM : '0;
   assign HRData   = MemRData;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed self-checking bench for cache_bus_arbiter with hand-computed expectations.
module tb_cache_bus_arbiter;
   import bus_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        HRequestF, HRequestM, HWriteM, MemReady;
   logic [31:0] HAddrF, HAddrM, HWDataM, MemRData;
   logic        HReadyF, HReadyM, MemReq, MemWrite;
   logic [31:0] HRData, MemAddr, MemWData;
   int          checks = 0;
   int          errors = 0;
   int          exp_beat;
   logic        mr;

   always #5 clk = ~clk;

   cache_bus_arbiter #(.BEATS(4), .ADDRW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .HRequestF (HRequestF),
      .HAddrF    (HAddrF),
      .HReadyF   (HReadyF),
      .HRequestM (HRequestM),
      .HWriteM   (HWriteM),
      .HAddrM    (HAddrM),
      .HWDataM   (HWDataM),
      .HReadyM   (HReadyM),
      .HRData    (HRData),
      .MemReq    (MemReq),
      .MemWrite  (MemWrite),
      .MemAddr   (MemAddr),
      .MemWData  (MemWData),
      .MemRData  (MemRData),
      .MemReady  (MemReady)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic rf, input logic [31:0] af, input logic rm,
                                input logic wm, input logic [31:0] am, input logic [31:0] wd,
                                input logic rdy, input logic [31:0] rd);
      HRequestF = rf;
      HAddrF    = af;
      HRequestM = rm;
      HWriteM   = wm;
      HAddrM    = am;
      HWDataM   = wd;
      MemReady  = rdy;
      MemRData  = rd;
      #2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
      checkOutput("rst_memreq", MemReq, 0);
      checkOutput("rst_readyf", HReadyF, 0);
      checkOutput("rst_readym", HReadyM, 0);
      checkOutput("rst_addr", MemAddr, 0);
      checkOutput("rst_rdata", HRData, 32'hDEADBEEF);
      tick();
      reset = 1'b0;
      tick();

      // Fetch-only burst at 0x100; ready in IDLE is ignored
      applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 0);
      checkOutput("f_idle_req", MemReq, 0);
      checkOutput("f_idle_ready", HReadyF, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 32'h100, 0, 0, 0, 0, 1, 32'h1000 + i);
         checkOutput("f_req", MemReq, 1);
         checkOutput("f_addr", MemAddr, 32'h100 + 4 * i);
         checkOutput("f_readyf", HReadyF, 1);
         checkOutput("f_readym", HReadyM, 0);
         checkOutput("f_write", MemWrite, 0);
         checkOutput("f_rdata", HRData, 32'h1000 + i);
         tick();
      end
      applyStimulus(0, 32'h100, 0, 0, 0, 0, 0, 0);
      checkOutput("f_drop_req", MemReq, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("f_after_idle", MemReq, 0);

      // Tie: M wins, then one IDLE cycle, then F from beat 0
      applyStimulus(1, 32'h500, 1, 0, 32'h600, 0, 0, 0);
      checkOutput("tie_idle", MemReq, 0);
      tick();
      applyStimulus(1, 32'h500, 1, 0, 32'h600, 0, 1, 0);
      checkOutput("tie_m_addr", MemAddr, 32'h600);
      checkOutput("tie_m_readym", HReadyM, 1);
      checkOutput("tie_m_readyf", HReadyF, 0);
      tick();
      applyStimulus(1, 32'h500, 0, 0, 32'h600, 0, 0, 0);
      checkOutput("tie_m_drop", MemReq, 0);
      tick();
      applyStimulus(1, 32'h500, 0, 0, 32'h600, 0, 0, 0);
      checkOutput("tie_gap", MemReq, 0);
      tick();
      applyStimulus(1, 32'h500, 0, 0, 32'h600, 0, 0, 0);
      checkOutput("tie_f_req", MemReq, 1);
      checkOutput("tie_f_addr", MemAddr, 32'h500);
      checkOutput("tie_f_write", MemWrite, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Dirty miss: 4 write beats then 4 read beats, no bubble
      applyStimulus(0, 0, 1, 1, 32'h2040, 32'hA0, 0, 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 1, (i < 4), 32'h2040, 32'hA0 + i, 1, 0);
         checkOutput("dm_req", MemReq, 1);
         checkOutput("dm_write", MemWrite, (i < 4) ? 1 : 0);
         checkOutput("dm_addr", MemAddr, 32'h2040 + 4 * (i % 4));
         checkOutput("dm_readym", HReadyM, 1);
         if (i < 4)
            checkOutput("dm_wdata", MemWData, 32'hA0 + i);
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Wait states: ready every third cycle
      applyStimulus(0, 0, 1, 0, 32'h3000, 0, 0, 0);
      tick();
      exp_beat = 0;
      for (int i = 0; i < 9; i++) begin
         mr = ((i % 3) == 2);
         applyStimulus(0, 0, 1, 0, 32'h3000, 0, mr, 32'h5000 + i);
         checkOutput("ws_readym", HReadyM, mr);
         checkOutput("ws_addr", MemAddr, 32'h3000 + 4 * exp_beat);
         checkOutput("ws_rdata", HRData, 32'h5000 + i);
         tick();
         if (mr) exp_beat = (exp_beat + 1) % 4;
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Abort after beat 1 with ready on the drop cycle
      applyStimulus(1, 32'h200, 0, 0, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 32'h200, 0, 0, 0, 0, 1, 0);
         checkOutput("ab_addr", MemAddr, 32'h200 + 4 * i);
         tick();
      end
      applyStimulus(0, 32'h200, 0, 0, 0, 0, 1, 0);
      checkOutput("ab_ready", HReadyF, 1);
      checkOutput("ab_req", MemReq, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("ab_idle", MemReq, 0);
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 1, 0);
      checkOutput("ab_restart", MemAddr, 32'h300);
      tick();
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 1, 0);
      checkOutput("ab_beat1", MemAddr, 32'h304);
      tick();

      // Asynchronous reset at beat 2
      applyStimulus(1, 32'h300, 0, 0, 0, 0, 1, 0);
      checkOutput("rm_beat2", MemAddr, 32'h308);
      #1 reset = 1'b1;
      #1;
      checkOutput("rm_req", MemReq, 0);
      checkOutput("rm_readyf", HReadyF, 0);
      checkOutput("rm_addr", MemAddr, 0);
      applyStimulus(1, 32'h300, 1, 0, 32'h700, 0, 0, 0);
      tick();
      reset = 1'b0;
      #1;
      checkOutput("rm_idle", MemReq, 0);
      tick();
      applyStimulus(1, 32'h300, 1, 0, 32'h700, 0, 1, 0);
      checkOutput("rm_tie_req", MemReq, 1);
      checkOutput("rm_tie_addr", MemAddr, 32'h700);
      checkOutput("rm_tie_readym", HReadyM, 1);
      checkOutput("rm_tie_readyf", HReadyF, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
